// File: rtl/packet_serializer.sv
// packet_serializer: sends a packet LSB nibble first over a 4-bit valid/ready link with sop/eop markers.
// Define PACKET_SERIALIZER_PARITY_EN to append an XOR parity nibble that carries eop.
module packet_serializer #(
  parameter int NIBBLES    = 6,
  parameter int GAP_CYCLES = 0
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [4*NIBBLES-1:0] packet_in,
  input  logic                 packet_valid,
  output logic                 packet_ready,
  output logic [3:0]           nib_out,
  output logic                 nib_valid,
  output logic                 nib_sop,
  output logic                 nib_eop,
  input  logic                 nib_ready,
  output logic                 busy
);
  localparam int IW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
`ifdef PACKET_SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SEND, PARITY, GAP} state_t;
  localparam bit PAR = 1'b1;
`else
  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
  localparam bit PAR = 1'b0;
`endif
  localparam state_t POST = (GAP_CYCLES > 0) ? GAP : IDLE;
`ifdef PACKET_SERIALIZER_PARITY_EN
  localparam state_t DATA_NEXT = PARITY;
`else
  localparam state_t DATA_NEXT = POST;
`endif
  state_t               state, state_d;
  logic [4*NIBBLES-1:0] data;
  logic [IW-1:0]        index;
  logic [3:0]           gap_cnt;
  logic                 accept, last, shift;
  assign packet_ready = state == IDLE && !clear;
  assign busy         = state != IDLE;
  assign accept       = packet_valid && packet_ready;
  assign last         = index == IW'(NIBBLES - 1);
  assign shift        = state == SEND && nib_ready;
`ifdef PACKET_SERIALIZER_PARITY_EN
  logic [3:0] par;
  always_ff @(posedge clock)
    par <= (clear || accept) ? 4'h0 : shift ? par ^ data[3:0] : par;
`endif
  always_ff @(posedge clock)
    state <= clear ? IDLE : state_d;
  always_comb begin
    state_d   = state;
    nib_valid = 1'b0;
    nib_out   = 4'h0;
    nib_sop   = 1'b0;
    nib_eop   = 1'b0;
    case (state)
      IDLE: state_d = accept ? SEND : IDLE;
      SEND: begin
        nib_valid = 1'b1;
        nib_out   = data[3:0];
        nib_sop   = index == '0;
        nib_eop   = last && !PAR;
        state_d   = (nib_ready && last) ? DATA_NEXT : SEND;
      end
`ifdef PACKET_SERIALIZER_PARITY_EN
      PARITY: begin
        nib_valid = 1'b1;
        nib_out   = par;
        nib_eop   = 1'b1;
        state_d   = nib_ready ? POST : PARITY;
      end
`endif
      GAP:     state_d = gap_cnt <= 4'd1 ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
  end
  // the hold register shifts right on each transfer so the current nibble is always data[3:0]
  always_ff @(posedge clock) begin
    if (clear) begin
      data    <= '0;
      index   <= '0;
      gap_cnt <= '0;
    end else begin
      if (accept) begin
        data  <= packet_in;
        index <= '0;
      end else if (shift) begin
        data  <= data >> 4;
        index <= last ? index : index + IW'(1);
      end
      if (state != GAP && state_d == GAP) gap_cnt <= 4'(GAP_CYCLES);
      else if (state == GAP) gap_cnt <= gap_cnt - 4'd1;
    end
  end
endmodule

// File: doc/packet_serializer.md
# packet_serializer

- Transmit-side counterpart to the packet register in the DisplayDecoderNoC datapath.
- Accepts one 24-bit display packet (six 4-bit nibbles) over a valid/ready handshake.
- Emits the packet nibble by nibble, least-significant nibble first, over a 4-bit link with its own valid/ready handshake, plus start- and end-of-packet markers.
- Sits between the packet source and the narrow NoC link that feeds downstream display decoders.

## Interface
- NIBBLES, 6, nibbles per packet; packet width = 4*NIBBLES.
- GAP_CYCLES, 0, idle cycles forced after each packet before the next is accepted (0..15).

- clock  in  1  single system clock, rising edge.
- clear  in  1  synchronous reset, active-high.
- packet_in  in  4*NIBBLES  packet to send; sampled only on accept.
- packet_valid  in  1  source has a packet.
- packet_ready  out  1  serializer can accept a packet.
- nib_out  out  4  current nibble.
- nib_valid  out  1  nib_out is valid.
- nib_sop  out  1  current nibble is the first of the packet.
- nib_eop  out  1  current nibble is the last of the packet.
- nib_ready  in  1  link sink accepts the nibble.
- busy  out  1  a packet is held, or a gap is in progress.

## Operation
- **States:**
  - IDLE: packet_ready=1.
  - SEND: emitting data nibbles.
  - PARITY: only when the parity feature is compiled in.
  - GAP: counting out GAP_CYCLES idle cycles.
- **Accept:** packet_valid && packet_ready at a clock edge.
  - Latch packet_in into an internal shift/hold register.
  - Index := 0; go to SEND.
- **SEND:**
  - nib_valid=1.
  - nib_out = nibble[index], where nibble[i] = packet[4i+3:4i].
  - nib_sop = (index==0).
  - nib_eop = (index==NIBBLES-1) and parity not enabled.
- **Transfer:** nib_valid && nib_ready at an edge.
  - Index increments (0..NIBBLES-1, no wrap past the last).
  - On the last data nibble: go to PARITY if enabled; else to GAP if GAP_CYCLES>0; else to IDLE.
- **Backpressure:** while nib_valid && !nib_ready, nib_out, nib_sop and nib_eop hold stable. No nibble is skipped or repeated.
- **GAP:** a counter loads GAP_CYCLES and decrements every cycle. On reaching 0, go to IDLE. nib_valid=0 and packet_ready=0 throughout.
- **packet_ready:** equals (state==IDLE) && !clear. packet_in is ignored in every other state.
- **busy:** equals (state!=IDLE).
- **Reset mid-operation:** clear high at any edge discards the held packet and any partial transfer. No eop is produced for the aborted packet. The next packet starts with sop.

## Timing
- **Reset values** (first cycle after an edge with clear=1): state IDLE, nib_valid=0, nib_out=0, nib_sop=0, nib_eop=0, busy=0, index=0, gap counter=0. packet_ready is 0 while clear is high and 1 the cycle after.
- **Accept-to-first-nibble latency:** 1 cycle. nib_valid rises in the cycle after the accept edge.
- **Throughput with nib_ready held high:** one nibble per cycle.
  - Packet occupies NIBBLES cycles (+1 with parity) + GAP_CYCLES + 1 IDLE cycle before the next accept.
  - With defaults, 7 cycles from one accept edge to the next.
- **No same-cycle overlap:** a new packet is never accepted in the cycle the last nibble transfers. packet_ready is 0 in SEND, PARITY and GAP.
- **Outputs:** nib_out, nib_valid, nib_sop and nib_eop are registered or decoded purely from state/index. None depends combinationally on nib_ready.

## Configuration
- **PACKET_SERIALIZER_PARITY_EN defined:**
  - After the last data nibble, one extra PARITY nibble is sent: the XOR of all NIBBLES data nibbles.
  - nib_eop is asserted on the parity nibble and not on the last data nibble.
  - The parity nibble obeys the same backpressure rules as data nibbles.
- **Not defined:**
  - No PARITY state.
  - nib_eop is on data nibble NIBBLES-1.
  - Packet length on the link is exactly NIBBLES.

## Test plan
- **Basic:** reset, then packet_in=24'hABC123, packet_valid pulse, nib_ready=1.
  - Required: nibbles 3,2,1,C,B,A on consecutive cycles starting 1 cycle after accept.
  - Required: sop only on 3, eop only on A, packet_ready back to 1 the cycle after A transfers.
- **Parity build:** same stimulus as Basic with the macro defined.
  - Required: seventh nibble 4'hD with eop; no eop on A.
- **Backpressure:** packet 24'h654321, nib_ready=0 for 3 cycles while nibble 2 is presented.
  - Required: nib_out=2 held stable with nib_valid=1 for 4 cycles.
  - Required: full sequence 1..6 delivered once, in order.
- **Back-to-back:** packet_valid held high with 24'h111111 then 24'h222222, GAP_CYCLES=0.
  - Required: second packet accepted exactly 1 cycle after the first packet's eop transfer.
  - Required: packet_in changes while busy are ignored.
- **Gap:** GAP_CYCLES=2.
  - Required: packet_ready stays 0 for 2 cycles after the eop transfer, then 1.
  - Required: nib_valid stays 0 throughout the gap.
- **Reset mid-packet:** assert clear after 3 nibbles of 24'hFEDCBA transfer, then send 24'h000007.
  - Required: all outputs at reset values and no eop for the aborted packet.
  - Required: next packet starts with sop on nibble 7.
